// File: rtl/fpcvt_sevenseg.sv
// Captures an FPCVT sign/exponent/significand result and scans it, plus a
// 4-bit conversion counter, onto a 4-digit common-anode seven-segment display.
module fpcvt_sevenseg #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned CNT_W    = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       S,
    input  logic [2:0] E,
    input  logic [3:0] F,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} dig_t;

    dig_t             dig_q, dig_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic             s_q, s_d;
    logic [2:0]       e_q, e_d;
    logic [3:0]       f_q, f_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             tc;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] r;
        unique case (v)
            4'h0: r = 7'b1000000;
            4'h1: r = 7'b1111001;
            4'h2: r = 7'b0100100;
            4'h3: r = 7'b0110000;
            4'h4: r = 7'b0011001;
            4'h5: r = 7'b0010010;
            4'h6: r = 7'b0000010;
            4'h7: r = 7'b1111000;
            4'h8: r = 7'b0000000;
            4'h9: r = 7'b0010000;
            4'hA: r = 7'b0001000;
            4'hB: r = 7'b0000011;
            4'hC: r = 7'b1000110;
            4'hD: r = 7'b0100001;
            4'hE: r = 7'b0000110;
            default: r = 7'b0001110;
        endcase
        return r;
    endfunction

    assign tc = (presc_q == CNT_W'(SCAN_DIV - 1));

    always_comb begin
        presc_d = presc_q + CNT_W'(1);
        dig_d   = dig_q;
        s_d     = s_q;
        e_d     = e_q;
        f_d     = f_q;
        cnt_d   = cnt_q;
        an_d    = 4'b1111;
        seg_d   = '1;
        dp_d    = 1'b1;

        if (tc) begin
            presc_d = '0;
            unique case (dig_q)
                DIG0: dig_d = DIG1;
                DIG1: dig_d = DIG2;
                DIG2: dig_d = DIG3;
                DIG3: dig_d = DIG0;
            endcase
        end

        if (load) begin
            s_d   = S;
            e_d   = E;
            f_d   = F;
            cnt_d = cnt_q + 4'd1;
        end

        // Output register decodes the pre-edge index and captured values.
        unique case (dig_q)
            DIG0: begin an_d = 4'b1110; seg_d = hex7(cnt_q); end
            DIG1: begin an_d = 4'b1101; seg_d = hex7(f_q); end
            DIG2: begin an_d = 4'b1011; seg_d = hex7({1'b0, e_q}); dp_d = 1'b0; end
            DIG3: begin an_d = 4'b0111; seg_d = s_q ? 7'b0111111 : 7'b1111111; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            dig_q   <= DIG0;
            s_q     <= 1'b0;
            e_q     <= '0;
            f_q     <= '0;
            cnt_q   <= '0;
            an_q    <= '1;
            seg_q   <= '1;
            dp_q    <= 1'b1;
        end else begin
            presc_q <= presc_d;
            dig_q   <= dig_d;
            s_q     <= s_d;
            e_q     <= e_d;
            f_q     <= f_d;
            cnt_q   <= cnt_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
